// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner with frame snapshot, guard blanking and leading-zero suppression.
// Outputs are registered (one-cycle latency); there is no backpressure, the scan free-runs.
module seg_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] c0,
  input  logic [3:0] c1,
  input  logic [3:0] c2,
  input  logic [3:0] c3,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int            CW        = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [6:0]    SEG_OFF   = 7'b1111111;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic          init_q, init_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;

  logic       tick;
  logic       load;
  logic       guard;
  logic       lz_blank;
  logic       z3, z2, z1;
  logic [3:0] digit;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = SEG_OFF;
    endcase
    return r;
  endfunction

  always_comb begin
    tick   = (cnt_q == CNT_MAX);
    cnt_d  = tick ? '0 : cnt_q + CW'(1);
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    // init_q catches the first edge after reset so the first frame shows live inputs
    load   = init_q | (tick & (idx_q == 2'd3));
    init_d = 1'b0;
    s0_d   = load ? c0 : s0_q;
    s1_d   = load ? c1 : s1_q;
    s2_d   = load ? c2 : s2_q;
    s3_d   = load ? c3 : s3_q;

    z3 = (s3_q == 4'd0);
    z2 = z3 & (s2_q == 4'd0);
    z1 = z2 & (s1_q == 4'd0);

    digit    = s0_q;
    lz_blank = 1'b0;
    case (idx_q)
      2'd0: begin digit = s0_q; lz_blank = 1'b0; end
      2'd1: begin digit = s1_q; lz_blank = z1;   end
      2'd2: begin digit = s2_q; lz_blank = z2;   end
      2'd3: begin digit = s3_q; lz_blank = z3;   end
      default: begin digit = s0_q; lz_blank = 1'b0; end
    endcase

    guard = (cnt_q < BLANK_END);
    an_d  = 4'b1111;
    seg_d = SEG_OFF;
    if (!guard) begin
      an_d[idx_q] = 1'b0;
      seg_d       = (blank_lz & lz_blank) ? SEG_OFF : dec7(digit);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      s0_q   <= 4'd0;
      s1_q   <= 4'd0;
      s2_q   <= 4'd0;
      s3_q   <= 4'd0;
      init_q <= 1'b1;
      seg_q  <= SEG_OFF;
      an_q   <= 4'b1111;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      s0_q   <= s0_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      init_q <= init_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan at REFRESH_DIV=8, BLANK_CYCLES=2; samples on the falling edge.
module tb_seg_scan;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] c0, c1, c2, c3;
  logic       blank_lz;
  logic [6:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D6 = 7'b0000010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;

  always #5 clock = ~clock;

  seg_scan #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .c0       (c0),
    .c1       (c1),
    .c2       (c2),
    .c3       (c3),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One slot: 2 guard cycles, then 6 cycles with an[slot] low and the digit pattern.
  task automatic check_slot(input string tag, input int slot, input logic [6:0] exp_seg);
    logic [3:0] en;
    en       = 4'b1111;
    en[slot] = 1'b0;
    for (int p = 0; p < 8; p++) begin
      @(negedge clock);
      if (p < 2) begin
        chk($sformatf("%s s%0d p%0d an", tag, slot, p), {28'd0, an}, 32'hf);
        chk($sformatf("%s s%0d p%0d seg", tag, slot, p), {25'd0, seg}, {25'd0, BL});
      end else begin
        chk($sformatf("%s s%0d p%0d an", tag, slot, p), {28'd0, an}, {28'd0, en});
        chk($sformatf("%s s%0d p%0d seg", tag, slot, p), {25'd0, seg}, {25'd0, exp_seg});
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    check_slot(tag, 0, e0);
    check_slot(tag, 1, e1);
    check_slot(tag, 2, e2);
    check_slot(tag, 3, e3);
  endtask

  task automatic skip_frame();
    repeat (32) @(negedge clock);
  endtask

  // Free-running monitor: one-hot-zero enables always, frame period while enabled.
  int   cyc = 0;
  int   onehot_err = 0;
  int   period_bad = 0;
  int   nper = 0;
  int   last_start = -1;
  logic mon_en = 1'b0;
  logic [3:0] prev_an = 4'hf;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if ($countones(~an) > 1) onehot_err++;
    if (mon_en && prev_an == 4'hf && an == 4'b1110) begin
      if (last_start >= 0) begin
        nper++;
        if (cyc - last_start != 32) period_bad++;
      end
      last_start = cyc;
    end
    prev_an = an;
  end

  initial begin
    reset = 1'b1;
    {c3, c2, c1, c0} = {4'd4, 4'd3, 4'd2, 4'd1};
    blank_lz = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset an", {28'd0, an}, 32'hf);
    chk("reset seg", {25'd0, seg}, {25'd0, BL});
    reset = 1'b0;

    check_frame("bcd4321", D1, D2, D3, D4);

    // Inputs changed inside slot 2 must not show until the next frame.
    check_slot("tear", 0, D1);
    check_slot("tear", 1, D2);
    repeat (3) @(negedge clock);
    c0 = 4'd7;
    c3 = 4'd9;
    repeat (5) @(negedge clock);
    check_slot("tear", 3, D4);
    check_frame("torn-next", D7, D2, D3, D9);

    {c3, c2, c1, c0} = {4'd0, 4'd0, 4'd5, 4'd0};
    blank_lz = 1'b1;
    skip_frame();
    check_frame("lz on", D0, D5, BL, BL);
    check_slot("lz live", 0, D0);
    check_slot("lz live", 1, D5);
    check_slot("lz live", 2, BL);
    blank_lz = 1'b0;
    check_slot("lz live", 3, D0);
    check_frame("lz off", D0, D5, D0, D0);

    {c3, c2, c1, c0} = 16'h0000;
    blank_lz = 1'b1;
    skip_frame();
    check_frame("all zero lz", D0, BL, BL, BL);

    {c3, c2, c1, c0} = {4'd0, 4'd1, 4'd0, 4'd0};
    skip_frame();
    check_frame("lz chain", D0, D0, D1, BL);

    {c3, c2, c1, c0} = {4'd8, 4'd6, 4'hF, 4'hA};
    blank_lz = 1'b0;
    skip_frame();
    check_frame("nonbcd", BL, BL, D6, D8);

    // Asynchronous reset in the active phase of slot 2.
    {c3, c2, c1, c0} = {4'd0, 4'd1, 4'd0, 4'd0};
    blank_lz = 1'b1;
    skip_frame();
    check_slot("pre-rst", 0, D0);
    check_slot("pre-rst", 1, D0);
    repeat (3) @(negedge clock);
    chk("pre-rst s2 an", {28'd0, an}, 32'hb);
    #2 reset = 1'b1;
    #1;
    chk("async rst an", {28'd0, an}, 32'hf);
    chk("async rst seg", {25'd0, seg}, {25'd0, BL});
    {c3, c2, c1, c0} = {4'd4, 4'd3, 4'd2, 4'd1};
    @(negedge clock);
    chk("held rst an", {28'd0, an}, 32'hf);
    reset = 1'b0;
    check_frame("after rst", D1, D2, D3, D4);

    mon_en = 1'b1;
    repeat (32 * 1000 + 4) @(negedge clock);
    mon_en = 1'b0;
    chk("onehot violations", onehot_err, 0);
    chk("period violations", period_bad, 0);
    chk("periods seen", {31'd0, nper >= 999}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clocks per digit slot; legal range BLANK_CYCLES+2 .. 2^20.
REQ-002 Parameter BLANK_CYCLES, default 500: anti-ghost guard clocks at the start of each slot; legal range 0 .. REFRESH_DIV-2.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 c0  input  4  BCD digit, units (rightmost).
REQ-006 c1  input  4  BCD digit, tens.
REQ-007 c2  input  4  BCD digit, hundreds.
REQ-008 c3  input  4  BCD digit, thousands (leftmost).
REQ-009 blank_lz  input  1  1 = suppress leading zeros on digits 3..1.
REQ-010 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 an  output  4  digit enables, active-low, an[i] selects digit i, registered.

Function
REQ-012 The prescaler cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; a tick is the cycle with cnt==REFRESH_DIV-1.
REQ-013 The slot index idx (2 bits) SHALL advance 0->1->2->3->0 on each tick edge.
REQ-014 The snapshot registers s0..s3 SHALL load c0..c3 on the tick edge with idx==3 and on the first rising edge after reset deasserts; they SHALL hold at all other times.
REQ-015 The block SHALL display only snapshot values; input changes mid-frame SHALL NOT appear before the next slot 0 (no tearing).
REQ-016 Outputs SHALL have one-cycle latency: an and seg after edge k reflect idx, cnt and snapshot as they were before edge k.
REQ-017 Guard phase (cnt < BLANK_CYCLES): an SHALL be 4'b1111 and seg 7'b1111111.
REQ-018 Active phase (cnt >= BLANK_CYCLES): an SHALL be all ones except bit idx, which is 0.
REQ-019 Decode (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-020 A snapshot digit of 10..15 SHALL decode to 1111111 (blank); an still asserts normally.
REQ-021 With blank_lz=1: digit 3 is blank if s3==0; digit 2 is blank if s3==s2==0; digit 1 is blank if s3==s2==s1==0; digit 0 is never blanked.
REQ-022 blank_lz SHALL be sampled live, not snapshotted; a change takes effect with the REQ-016 latency.
REQ-023 A blanked digit SHALL drive seg=1111111 with an asserted normally.
REQ-024 At most one an bit SHALL be 0 on any cycle, including across slot boundaries and reset.
REQ-025 Frame period SHALL be exactly 4*REFRESH_DIV clocks.

Reset
REQ-026 While reset is high, asynchronously: cnt=0, idx=0, s0..s3=0, an=4'b1111, seg=7'b1111111.
REQ-027 Assertion of reset mid-slot SHALL force REQ-026 values with no clock edge required.
REQ-028 After reset release, the first slot SHALL be idx 0 with a full guard phase, then REQ-014 snapshot timing.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-029 Reset pulsed mid-slot 2 -> an=1111 and seg=1111111 before the next edge; after release, slot 0 restarts with a 2-cycle guard.
REQ-030 c3..c0=4,3,2,1, blank_lz=0 -> each slot shows 2 cycles of an=1111, then 6 cycles of the enable; an sequence 1110/1101/1011/0111 with seg 1111001/0100100/0110000/0011001.
REQ-031 c3..c0=0,0,5,0, blank_lz=1 -> digits 3 and 2 show 1111111, digit 1 shows 0010010, digit 0 shows 1000000; with blank_lz=0, digits 3 and 2 show 1000000.
REQ-032 Change c0 from 1 to 7 during slot 2 -> digit 0 shows 1111001 until after the next idx 3->0 tick, then 1111000.
REQ-033 c0=4'hA, c1=4'hF -> digits 0 and 1 show 1111111 while an still asserts.
REQ-034 A checker asserts over 1000 frames: an is never one-hot-zero on two bits, and the frame period is 32 clocks.
